// File: rtl/b1_pkg.sv
// Shared definitions for the B1 report framer: sync bytes, packet geometry,
// FSM encoding and per-channel payload field offsets.
package b1_pkg;

    localparam logic [7:0] HDR0_DEFAULT = 8'hEB;
    localparam logic [7:0] HDR1_DEFAULT = 8'h90;

    localparam int PAY_LEN  = 32;
    localparam int PKT_LEN  = 37;
    localparam int CH_BYTES = 16;

    // Byte indices inside the packet (checksum is sent from its own state).
    localparam logic [5:0] IDX_HDR1     = 6'd1;
    localparam logic [5:0] IDX_SEQ      = 6'd2;
    localparam logic [5:0] IDX_LEN      = 6'd3;
    localparam logic [5:0] IDX_PAY      = 6'd4;
    localparam logic [5:0] IDX_LAST_PAY = 6'd35;

    // Byte offsets of each field inside one 16-byte channel block.
    localparam int OFF_CAR_NCO  = 0;
    localparam int OFF_PRN_NCO  = 4;
    localparam int OFF_PRN_PHS  = 8;
    localparam int OFF_BBP_REAL = 10;
    localparam int OFF_BBP_IMAG = 13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_CSUM = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] car_nco;
        logic [31:0] prn_nco;
        logic [11:0] prn_phs;
        logic [23:0] bbp_real;
        logic [23:0] bbp_imag;
    } chan_t;

endpackage

// File: rtl/b1_rpt_snapshot.sv
// Snapshot registers for both tracking channels plus the byte-select mux
// that serves payload bytes by packet byte index.
module b1_rpt_snapshot
    import b1_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  chan_t      boc,
    input  chan_t      tmboc,
    input  logic [5:0] sel,
    output logic [7:0] byte_out
);

    chan_t snap_reg [2];
    logic [PAY_LEN-1:0][7:0] pay_bytes;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_reg[0] <= '0;
            snap_reg[1] <= '0;
        end else if (load) begin
            snap_reg[0] <= boc;
            snap_reg[1] <= tmboc;
        end
    end

    // Big-endian byte image: BOC block first, TMBOC block second.
    for (genvar gc = 0; gc < 2; gc++) begin : g_ch
        localparam int BASE = gc * CH_BYTES;
        for (genvar gi = 0; gi < 4; gi++) begin : g_nco
            assign pay_bytes[BASE + OFF_CAR_NCO + gi] = snap_reg[gc].car_nco[31 - 8*gi -: 8];
            assign pay_bytes[BASE + OFF_PRN_NCO + gi] = snap_reg[gc].prn_nco[31 - 8*gi -: 8];
        end
        assign pay_bytes[BASE + OFF_PRN_PHS]     = {4'h0, snap_reg[gc].prn_phs[11:8]};
        assign pay_bytes[BASE + OFF_PRN_PHS + 1] = snap_reg[gc].prn_phs[7:0];
        for (genvar gi = 0; gi < 3; gi++) begin : g_acc
            assign pay_bytes[BASE + OFF_BBP_REAL + gi] = snap_reg[gc].bbp_real[23 - 8*gi -: 8];
            assign pay_bytes[BASE + OFF_BBP_IMAG + gi] = snap_reg[gc].bbp_imag[23 - 8*gi -: 8];
        end
    end

    // Header indices 0..3 fall outside the payload window and read as zero.
    always_comb begin
        byte_out = 8'h00;
        for (int i = 0; i < PAY_LEN; i++) begin
            if (sel == IDX_PAY + 6'(i)) begin
                byte_out = pay_bytes[i];
            end
        end
    end

endmodule

// File: rtl/b1_report_framer.sv
// Captures both B1 channels on an enabled PPS strobe and streams a 37-byte
// framed packet (sync, seq, length, payload, checksum) over valid/ready.
module b1_report_framer
    import b1_pkg::*;
#(
    parameter logic [7:0] HDR0 = HDR0_DEFAULT,
    parameter logic [7:0] HDR1 = HDR1_DEFAULT
) (
    input  logic        rx_clk,
    input  logic        rx_rst,
    input  logic        rx_pps,
    input  logic        rx_en,
    input  logic [31:0] rx_boc_car_nco,
    input  logic [31:0] rx_boc_prn_nco,
    input  logic [11:0] rx_boc_prn_phs,
    input  logic [23:0] rx_bbP_real,
    input  logic [23:0] rx_bbP_imag,
    input  logic [31:0] rx_tmboc_car_nco,
    input  logic [31:0] rx_tmboc_prn_nco,
    input  logic [11:0] rx_tmboc_prn_phs,
    input  logic [23:0] rx_tmbbP_real,
    input  logic [23:0] rx_tmbbP_imag,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_busy,
    output logic [7:0]  tx_overrun
);

    state_t     state_reg;
    logic [5:0] idx_reg;
    logic [7:0] seq_reg;
    logic [7:0] csum_reg;
    logic [7:0] ovr_reg;
    logic [7:0] tx_byte_reg;
    logic       tx_valid_reg;
    logic       tx_busy_reg;

    logic [5:0] idx_next;
    logic [7:0] snap_byte;
    logic [7:0] byte_next;
    logic       accept;
    logic       start;
    logic       drop;
    chan_t      boc_in;
    chan_t      tmboc_in;

    assign boc_in   = {rx_boc_car_nco, rx_boc_prn_nco, rx_boc_prn_phs, rx_bbP_real, rx_bbP_imag};
    assign tmboc_in = {rx_tmboc_car_nco, rx_tmboc_prn_nco, rx_tmboc_prn_phs,
                       rx_tmbbP_real, rx_tmbbP_imag};

    assign idx_next = idx_reg + 6'd1;
    assign accept   = tx_valid_reg & tx_ready;
    assign start    = rx_pps & rx_en & (state_reg == ST_IDLE);
    // Any strobe outside IDLE is lost, including one on the checksum handoff.
    assign drop     = rx_pps & (state_reg != ST_IDLE);

    b1_rpt_snapshot u_snapshot (
        .clk      (rx_clk),
        .rst      (rx_rst),
        .load     (start),
        .boc      (boc_in),
        .tmboc    (tmboc_in),
        .sel      (idx_next),
        .byte_out (snap_byte)
    );

    always_comb begin
        byte_next = snap_byte;
        case (idx_next)
            IDX_HDR1: byte_next = HDR1;
            IDX_SEQ:  byte_next = seq_reg;
            IDX_LEN:  byte_next = 8'(PAY_LEN);
            default:  byte_next = snap_byte;
        endcase
    end

    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            state_reg    <= ST_IDLE;
            idx_reg      <= 6'd0;
            seq_reg      <= 8'd0;
            csum_reg     <= 8'd0;
            ovr_reg      <= 8'd0;
            tx_byte_reg  <= 8'd0;
            tx_valid_reg <= 1'b0;
            tx_busy_reg  <= 1'b0;
        end else begin
            if (drop && ovr_reg != 8'hFF) begin
                ovr_reg <= ovr_reg + 8'd1;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg    <= ST_SEND;
                        idx_reg      <= 6'd0;
                        tx_byte_reg  <= HDR0;
                        tx_valid_reg <= 1'b1;
                        tx_busy_reg  <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (accept) begin
                        idx_reg <= idx_next;
                        if (idx_reg >= IDX_SEQ) begin
                            csum_reg <= csum_reg + tx_byte_reg;
                        end
                        // Fold the last payload byte in directly so the sum is ready now.
                        if (idx_reg == IDX_LAST_PAY) begin
                            state_reg   <= ST_CSUM;
                            tx_byte_reg <= csum_reg + tx_byte_reg;
                        end else begin
                            tx_byte_reg <= byte_next;
                        end
                    end
                end
                ST_CSUM: begin
                    if (accept) begin
                        state_reg    <= ST_IDLE;
                        tx_valid_reg <= 1'b0;
                        tx_busy_reg  <= 1'b0;
                        seq_reg      <= seq_reg + 8'd1;
                        csum_reg     <= 8'd0;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign tx_byte    = tx_byte_reg;
    assign tx_valid   = tx_valid_reg;
    assign tx_busy    = tx_busy_reg;
    assign tx_overrun = ovr_reg;

endmodule

// File: tb/tb_b1_report_framer.sv
// Directed bench for b1_report_framer: a packet model fills a byte scoreboard
// on each PPS and a negedge monitor pops and compares every accepted byte.
module tb_b1_report_framer;

    logic        rx_clk = 1'b0;
    logic        rx_rst;
    logic        rx_pps;
    logic        rx_en;
    logic [31:0] rx_boc_car_nco;
    logic [31:0] rx_boc_prn_nco;
    logic [11:0] rx_boc_prn_phs;
    logic [23:0] rx_bbP_real;
    logic [23:0] rx_bbP_imag;
    logic [31:0] rx_tmboc_car_nco;
    logic [31:0] rx_tmboc_prn_nco;
    logic [11:0] rx_tmboc_prn_phs;
    logic [23:0] rx_tmbbP_real;
    logic [23:0] rx_tmbbP_imag;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_busy;
    logic [7:0]  tx_overrun;

    b1_report_framer dut (
        .rx_clk           (rx_clk),
        .rx_rst           (rx_rst),
        .rx_pps           (rx_pps),
        .rx_en            (rx_en),
        .rx_boc_car_nco   (rx_boc_car_nco),
        .rx_boc_prn_nco   (rx_boc_prn_nco),
        .rx_boc_prn_phs   (rx_boc_prn_phs),
        .rx_bbP_real      (rx_bbP_real),
        .rx_bbP_imag      (rx_bbP_imag),
        .rx_tmboc_car_nco (rx_tmboc_car_nco),
        .rx_tmboc_prn_nco (rx_tmboc_prn_nco),
        .rx_tmboc_prn_phs (rx_tmboc_prn_phs),
        .rx_tmbbP_real    (rx_tmbbP_real),
        .rx_tmbbP_imag    (rx_tmbbP_imag),
        .tx_byte          (tx_byte),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready),
        .tx_busy          (tx_busy),
        .tx_overrun       (tx_overrun)
    );

    always #5 rx_clk = ~rx_clk;

    int         vec_cnt = 0;
    int         err_cnt = 0;
    logic [7:0] sb [$];
    logic [7:0] pk_q [$];
    logic [7:0] rx_pkt [37];
    int         rcv_idx = 0;
    logic [7:0] m_seq = 8'd0;
    logic [7:0] m_ovr = 8'd0;
    bit         m_busy = 1'b0;
    bit         hold_pend = 1'b0;
    logic [7:0] hold_byte = 8'd0;
    bit         rand_ready = 1'b0;
    logic [8:0] exp9;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic add_word(input logic [31:0] w, input int nbytes);
        for (int i = nbytes - 1; i >= 0; i--) pk_q.push_back(w[8*i +: 8]);
    endtask

    task automatic push_packet();
        logic [7:0] cs;
        pk_q.delete();
        pk_q.push_back(8'hEB);
        pk_q.push_back(8'h90);
        pk_q.push_back(m_seq);
        pk_q.push_back(8'd32);
        add_word(rx_boc_car_nco, 4);
        add_word(rx_boc_prn_nco, 4);
        add_word({20'd0, rx_boc_prn_phs}, 2);
        add_word({8'd0, rx_bbP_real}, 3);
        add_word({8'd0, rx_bbP_imag}, 3);
        add_word(rx_tmboc_car_nco, 4);
        add_word(rx_tmboc_prn_nco, 4);
        add_word({20'd0, rx_tmboc_prn_phs}, 2);
        add_word({8'd0, rx_tmbbP_real}, 3);
        add_word({8'd0, rx_tmbbP_imag}, 3);
        cs = 8'd0;
        for (int i = 2; i < 36; i++) cs += pk_q[i];
        pk_q.push_back(cs);
        foreach (pk_q[i]) sb.push_back(pk_q[i]);
        m_seq++;
    endtask

    // Called at posedge+1; drives a one-cycle strobe and updates the model.
    task automatic pulse_pps();
        bit starts;
        starts = rx_en && !m_busy;
        rx_pps = 1'b1;
        if (starts) begin
            push_packet();
            m_busy = 1'b1;
        end else if (m_busy && m_ovr != 8'hFF) begin
            m_ovr++;
        end
        @(posedge rx_clk); #1;
        rx_pps = 1'b0;
        if (starts) begin
            check("lat_valid", {31'd0, tx_valid}, 32'd1);
            check("lat_hdr0", {24'd0, tx_byte}, 32'hEB);
            check("lat_busy", {31'd0, tx_busy}, 32'd1);
        end
        check("overrun", {24'd0, tx_overrun}, {24'd0, m_ovr});
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((m_busy || sb.size() != 0) && n < budget) begin
            if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
            @(posedge rx_clk); #1;
            n++;
        end
        tx_ready = 1'b1;
        check("done_busy", {31'd0, tx_busy}, 32'd0);
        check("done_sb_empty", sb.size(), 32'd0);
    endtask

    task automatic wait_bytes(input int k, input int budget);
        int n = 0;
        while (rcv_idx < k && n < budget) begin
            @(posedge rx_clk); #1;
            n++;
        end
        check($sformatf("reach_byte%0d", k), rcv_idx, k);
    endtask

    task automatic idle_check(input int cycles);
        repeat (cycles) @(posedge rx_clk);
        #1;
        check("idle_valid", {31'd0, tx_valid}, 32'd0);
        check("idle_busy", {31'd0, tx_busy}, 32'd0);
    endtask

    // Byte monitor: sees the handshake half a cycle before the accepting edge.
    always @(negedge rx_clk) begin
        if (rx_rst) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("hold_valid", {31'd0, tx_valid}, 32'd1);
                check("hold_byte", {24'd0, tx_byte}, {24'd0, hold_byte});
            end
            if (tx_valid && tx_ready) begin
                exp9 = (sb.size() > 0) ? {1'b0, sb.pop_front()} : 9'h100;
                check($sformatf("byte%0d", rcv_idx), {24'd0, tx_byte}, {23'd0, exp9});
                if (rcv_idx < 37) rx_pkt[rcv_idx] = tx_byte;
                rcv_idx++;
                if (rcv_idx == 37) begin
                    $display("packet seq=%02h csum=%02h overrun=%0d", rx_pkt[2], rx_pkt[36], tx_overrun);
                    rcv_idx = 0;
                    m_busy  = 1'b0;
                end
            end
            hold_pend = tx_valid && !tx_ready;
            hold_byte = tx_byte;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit saw_ff;
        int busy_len;
        rx_rst = 1'b1; rx_pps = 1'b0; rx_en = 1'b1; tx_ready = 1'b1;
        rx_boc_car_nco = '0; rx_boc_prn_nco = '0; rx_boc_prn_phs = '0;
        rx_bbP_real = '0; rx_bbP_imag = '0;
        rx_tmboc_car_nco = '0; rx_tmboc_prn_nco = '0; rx_tmboc_prn_phs = '0;
        rx_tmbbP_real = '0; rx_tmbbP_imag = '0;
        repeat (3) @(posedge rx_clk);
        #1;
        check("rst_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_busy", {31'd0, tx_busy}, 32'd0);
        check("rst_byte", {24'd0, tx_byte}, 32'd0);
        check("rst_overrun", {24'd0, tx_overrun}, 32'd0);
        rx_rst = 1'b0;
        @(posedge rx_clk); #1;

        // All-zero snapshot, ready tied high: 37 back-to-back bytes.
        pulse_pps();
        busy_len = 1;
        @(posedge rx_clk); #1;
        while (tx_busy && busy_len < 100) begin
            busy_len++;
            @(posedge rx_clk); #1;
        end
        check("busy_len", busy_len, 32'd37);
        check("p0_sb_empty", sb.size(), 32'd0);
        check("p0_csum", {24'd0, rx_pkt[36]}, 32'h20);

        // Field placement.
        rx_boc_car_nco   = 32'h12345678;
        rx_bbP_real      = 24'hFFFF80;
        rx_tmboc_prn_phs = 12'hABC;
        pulse_pps();
        wait_done(200);
        check("p1_seq", {24'd0, rx_pkt[2]}, 32'h01);
        check("p1_b4", {24'd0, rx_pkt[4]}, 32'h12);
        check("p1_b5", {24'd0, rx_pkt[5]}, 32'h34);
        check("p1_b6", {24'd0, rx_pkt[6]}, 32'h56);
        check("p1_b7", {24'd0, rx_pkt[7]}, 32'h78);
        check("p1_b14", {24'd0, rx_pkt[14]}, 32'hFF);
        check("p1_b15", {24'd0, rx_pkt[15]}, 32'hFF);
        check("p1_b16", {24'd0, rx_pkt[16]}, 32'h80);
        check("p1_b28", {24'd0, rx_pkt[28]}, 32'h0A);
        check("p1_b29", {24'd0, rx_pkt[29]}, 32'hBC);

        // Random data with random backpressure.
        rx_boc_car_nco = $urandom; rx_boc_prn_nco = $urandom;
        rx_boc_prn_phs = 12'($urandom); rx_bbP_real = 24'($urandom); rx_bbP_imag = 24'($urandom);
        rx_tmboc_car_nco = $urandom; rx_tmboc_prn_nco = $urandom;
        rx_tmboc_prn_phs = 12'($urandom); rx_tmbbP_real = 24'($urandom);
        rx_tmbbP_imag = 24'($urandom);
        pulse_pps();
        rand_ready = 1'b1;
        wait_done(2000);
        rand_ready = 1'b0;
        check("p2_seq", {24'd0, rx_pkt[2]}, 32'h02);

        // PPS mid-packet is dropped and counted; snapshot must not change.
        pulse_pps();
        wait_bytes(10, 100);
        rx_boc_car_nco = 32'hDEADBEEF;
        pulse_pps();
        wait_done(200);
        check("ovr_one", {24'd0, tx_overrun}, 32'd1);
        idle_check(20);

        // PPS on the checksum acceptance cycle is an overrun, not a start.
        pulse_pps();
        wait_bytes(36, 100);
        pulse_pps();
        wait_done(50);
        check("ovr_two", {24'd0, tx_overrun}, 32'd2);
        idle_check(20);

        // Saturation while stalled on the first byte.
        tx_ready = 1'b0;
        pulse_pps();
        for (int i = 0; i < 300; i++) begin
            pulse_pps();
            @(posedge rx_clk); #1;
        end
        check("ovr_sat", {24'd0, tx_overrun}, 32'd255);
        tx_ready = 1'b1;
        wait_done(200);

        // Reset mid-packet.
        pulse_pps();
        wait_bytes(20, 100);
        rx_rst = 1'b1;
        #1;
        check("mid_rst_valid", {31'd0, tx_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, tx_busy}, 32'd0);
        check("mid_rst_byte", {24'd0, tx_byte}, 32'd0);
        check("mid_rst_ovr", {24'd0, tx_overrun}, 32'd0);
        sb.delete();
        rcv_idx = 0;
        m_busy  = 1'b0;
        m_seq   = 8'd0;
        m_ovr   = 8'd0;
        @(posedge rx_clk); #1;
        rx_rst = 1'b0;
        @(posedge rx_clk); #1;
        pulse_pps();
        wait_done(200);
        check("post_rst_b0", {24'd0, rx_pkt[0]}, 32'hEB);
        check("post_rst_b1", {24'd0, rx_pkt[1]}, 32'h90);
        check("post_rst_seq", {24'd0, rx_pkt[2]}, 32'h00);

        // Disabled strobes neither start a packet nor count as overrun.
        rx_en = 1'b0;
        pulse_pps();
        idle_check(20);
        check("dis_ovr", {24'd0, tx_overrun}, 32'd0);
        rx_en = 1'b1;

        // Sequence wrap: packets seq 01..FF then 00.
        saw_ff = 1'b0;
        for (int i = 0; i < 256; i++) begin
            pulse_pps();
            wait_done(200);
            if (rx_pkt[2] == 8'hFF) saw_ff = 1'b1;
        end
        check("wrap_saw_ff", {31'd0, saw_ff}, 32'd1);
        check("wrap_seq00", {24'd0, rx_pkt[2]}, 32'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
